// File: rtl/simmem_delay_calc.sv
// simmem_delay_calc: DRAM-like release delay model for simmem entries.
// Tracks per-bank open row and residual busy time; one delay per request.
module simmem_delay_calc #(
    parameter int AddrWidth    = 32,
    parameter int NumBanks     = 8,
    parameter int BankLsb      = 13,
    parameter int RowWidth     = 14,
    parameter int CounterWidth = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AddrWidth-1:0]    req_addr_i,
    output logic                    delay_valid_o,
    input  logic                    delay_ready_i,
    output logic [CounterWidth-1:0] delay_o,
    input  logic [CounterWidth-1:0] cfg_tcl_i,
    input  logic [CounterWidth-1:0] cfg_trcd_i,
    input  logic [CounterWidth-1:0] cfg_trp_i,
    input  logic                    flush_i
);

    localparam int BankW = $clog2(NumBanks);
    localparam int SumW  = CounterWidth + 2;
    localparam int RowLsb = BankLsb + BankW;

    logic [NumBanks-1:0]     open_q;
    logic [RowWidth-1:0]     row_q  [NumBanks];
    logic [CounterWidth-1:0] busy_q [NumBanks];

    logic [BankW-1:0]        bank;
    logic [RowWidth-1:0]     row;
    logic                    accept;
    logic                    hit;
    logic [SumW-1:0]         base;
    logic [SumW-1:0]         sum;
    logic [CounterWidth-1:0] delay;
    logic                    unused_addr;

    assign bank        = req_addr_i[BankLsb +: BankW];
    assign row         = req_addr_i[RowLsb +: RowWidth];
    assign unused_addr = ^req_addr_i;

    assign req_ready_o = ~flush_i && (~delay_valid_o || delay_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign hit         = open_q[bank] && (row_q[bank] == row);

    always_comb begin
        base = '0;
        unique case (1'b1)
            hit: begin
                base = SumW'(cfg_tcl_i);
            end
            !open_q[bank]: begin
                base = SumW'(cfg_trcd_i) + SumW'(cfg_tcl_i);
            end
            default: begin
                base = SumW'(cfg_trp_i) + SumW'(cfg_trcd_i)
                     + SumW'(cfg_tcl_i);
            end
        endcase
    end

    // The wide sum cannot wrap; any carry out of CounterWidth saturates.
    always_comb begin
        sum   = SumW'(busy_q[bank]) + base;
        delay = sum[CounterWidth-1:0];
        if (sum[SumW-1:CounterWidth] != '0) begin
            delay = {CounterWidth{1'b1}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_q <= '0;
            for (int i = 0; i < NumBanks; i++) begin
                row_q[i]  <= '0;
                busy_q[i] <= '0;
            end
        end else if (flush_i) begin
            open_q <= '0;
            for (int i = 0; i < NumBanks; i++) begin
                busy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumBanks; i++) begin
                if (accept && (bank == BankW'(i))) begin
                    open_q[i] <= 1'b1;
                    row_q[i]  <= row;
                    busy_q[i] <= delay;
                end else if (busy_q[i] != '0) begin
                    busy_q[i] <= busy_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            delay_valid_o <= 1'b0;
            delay_o       <= '0;
        end else if (accept) begin
            delay_valid_o <= 1'b1;
            delay_o       <= delay;
        end else if (delay_ready_i) begin
            delay_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_simmem_delay_calc.sv
// Directed and randomized bench for simmem_delay_calc against a
// bank-level timing model kept in plain integer arrays.
module tb_simmem_delay_calc;

    localparam int NB   = 8;
    localparam int MAXV = 255;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic       delay_valid_o;
    logic       delay_ready_i = 1'b0;
    logic [7:0] delay_o;
    logic [7:0] cfg_tcl_i = 8'd4;
    logic [7:0] cfg_trcd_i = 8'd3;
    logic [7:0] cfg_trp_i = 8'd2;
    logic       flush_i = 1'b0;

    simmem_delay_calc dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .delay_valid_o (delay_valid_o),
        .delay_ready_i (delay_ready_i),
        .delay_o       (delay_o),
        .cfg_tcl_i     (cfg_tcl_i),
        .cfg_trcd_i    (cfg_trcd_i),
        .cfg_trp_i     (cfg_trp_i),
        .flush_i       (flush_i)
    );

    always #5 clk_i = ~clk_i;

    int nvec = 0;
    int nerr = 0;
    int m_open [NB];
    int m_row  [NB];
    int m_busy [NB];
    int m_valid;
    int m_delay;

    task automatic chk(string tag, int obs, int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int A(int b, int r);
        return (r << 16) | (b << 13);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 0;
            m_row[i]  = 0;
            m_busy[i] = 0;
        end
        m_valid = 0;
        m_delay = 0;
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        delay_ready_i = 1'b0;
        flush_i       = 1'b0;
        #1;
        chk("rst_valid", int'(delay_valid_o), 0);
        chk("rst_delay", int'(delay_o), 0);
        model_reset();
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic cycle(int v, int addr, int rdy, int fl);
        int exp_ready, acc, b, r, base, d;
        req_valid_i   = v[0];
        req_addr_i    = addr;
        delay_ready_i = rdy[0];
        flush_i       = fl[0];
        #1;
        exp_ready = (fl == 0 && (m_valid == 0 || rdy != 0)) ? 1 : 0;
        chk("req_ready", int'(req_ready_o), exp_ready);
        acc = (v != 0 && exp_ready != 0) ? 1 : 0;
        b = (addr >> 13) & (NB - 1);
        r = (addr >> 16) & 'h3fff;
        d = 0;
        if (acc != 0) begin
            if (m_open[b] != 0 && m_row[b] == r)
                base = int'(cfg_tcl_i);
            else if (m_open[b] == 0)
                base = int'(cfg_trcd_i) + int'(cfg_tcl_i);
            else
                base = int'(cfg_trp_i) + int'(cfg_trcd_i) + int'(cfg_tcl_i);
            d = m_busy[b] + base;
            if (d > MAXV) d = MAXV;
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NB; i++) begin
            if (fl != 0) begin
                m_open[i] = 0;
                m_busy[i] = 0;
            end else if (acc != 0 && i == b) begin
                m_open[i] = 1;
                m_row[i]  = r;
                m_busy[i] = d;
            end else if (m_busy[i] > 0) begin
                m_busy[i]--;
            end
        end
        if (acc != 0) begin
            m_valid = 1;
            m_delay = d;
        end else if (rdy != 0) begin
            m_valid = 0;
        end
        chk("delay_valid", int'(delay_valid_o), m_valid);
        if (m_valid != 0) chk("delay", int'(delay_o), m_delay);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, 0);
    endtask

    initial begin
        int held;
        do_reset();

        cycle(1, A(0, 5), 1, 0);
        chk("closed", int'(delay_o), 7);
        idle(20);
        cycle(1, A(0, 5), 1, 0);
        chk("hit", int'(delay_o), 4);
        idle(20);
        cycle(1, A(0, 6), 1, 0);
        chk("miss", int'(delay_o), 9);

        idle(20);
        cycle(1, A(1, 0), 1, 0);
        chk("busy_first", int'(delay_o), 7);
        cycle(1, A(1, 0), 1, 0);
        chk("busy_accum", int'(delay_o), 11);
        cycle(1, A(2, 0), 1, 0);
        chk("busy_indep", int'(delay_o), 7);

        cfg_tcl_i  = 8'd200;
        cfg_trcd_i = 8'd100;
        cycle(1, A(3, 0), 1, 0);
        chk("sat_closed", int'(delay_o), 255);
        cycle(1, A(3, 0), 1, 0);
        chk("sat_hit", int'(delay_o), 255);
        cfg_tcl_i  = 8'd4;
        cfg_trcd_i = 8'd3;

        idle(40);
        cycle(1, A(4, 1), 0, 0);
        held = int'(delay_o);
        chk("bp_first", held, 7);
        for (int i = 0; i < 5; i++) begin
            cycle(1, A(0, 7), 0, 0);
            chk("bp_ready_low", int'(req_ready_o), 0);
            chk("bp_held", int'(delay_o), held);
        end
        cycle(1, A(0, 7), 1, 0);
        chk("bp_reload_valid", int'(delay_valid_o), 1);
        chk("bp_reload", int'(delay_o), 9);

        idle(20);
        cycle(1, A(0, 5), 1, 0);
        cycle(1, A(0, 5), 1, 1);
        chk("flush_ready", int'(req_ready_o), 0);
        cycle(1, A(0, 5), 1, 0);
        chk("after_flush", int'(delay_o), 7);

        cycle(1, A(1, 1), 0, 0);
        do_reset();

        for (int n = 0; n < 400; n++) begin
            int addr;
            if (n % 50 == 0) begin
                cfg_tcl_i  = 8'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 150 : 8));
                cfg_trcd_i = 8'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 150 : 8));
                cfg_trp_i  = 8'($urandom_range(0, 8));
            end
            addr = ($urandom_range(0, 3) << 30) | (A($urandom_range(0, NB - 1),
                   $urandom_range(0, 3))) | $urandom_range(0, 'h1fff);
            cycle(($urandom_range(0, 3) != 0) ? 1 : 0, addr,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  ($urandom_range(0, 31) == 0) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
